reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 31 +++
 rtl/bit_sync.sv | 33 +++
 rtl/reset_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the reset sequencer family: FSM state encoding,
// default parameter values and a small abort-condition helper.
// ---------------------------------------------------------------------------
package reset_sequencer_pkg;

    // Default parameter values shared by every sequencer instance.
    localparam int unsigned DEF_N_OUT          = 4;
    localparam int unsigned DEF_HOLD_CYCLES    = 10;
    localparam int unsigned DEF_STAGGER_CYCLES = 4;
    localparam int unsigned DEF_LOCK_FILTER    = 3;

    localparam int unsigned SEQ_STATE_W = 3;

    // Sequencer FSM states.
    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    // A sequence that has qualified lock is torn down on lock loss or a
    // software request.
    function automatic logic seq_abort(input logic lock_s, input logic sw_req);
        return (!lock_s) || sw_req;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   pclk  - destination clock (rising edge)
//   rst_n - synchronous active-low reset, clears both flops
//   i_d   - asynchronous input
//   o_q   - synchronised output (two pclk cycles of latency)
// ---------------------------------------------------------------------------
module bit_sync (
    input  logic pclk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a cycle to resolve.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Qualifies PLL lock, holds all downstream resets for a fixed time, then
// releases them one by one in ascending index order with a fixed stagger.
// Lock loss or a software request tears the sequence down again.
// Ports:
//   pclk         - sole clock (rising edge)
//   rst_n        - synchronous active-low reset
//   locked       - PLL/MMCM lock, asynchronous to pclk
//   sw_reset_req - single-cycle software reset request (pclk domain)
//   reset_out    - active-high reset per downstream domain, bit k releases k-th
//   done         - every reset_out bit released
//   busy         - sequencer not in RUN
// ---------------------------------------------------------------------------
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned N_OUT          = DEF_N_OUT,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int unsigned LOCK_FILTER    = DEF_LOCK_FILTER
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             sw_reset_req,
    output logic [N_OUT-1:0] reset_out,
    output logic             done,
    output logic             busy
);

    localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned STAG_W = $clog2(STAGGER_CYCLES + 1);
    localparam int unsigned IDX_W  = $clog2(N_OUT + 1);

    // Counter values on the cycle before their threshold is reached.
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_OUT - 1);
    localparam logic [N_OUT-1:0]  ALL_ON    = '1;
    localparam logic [N_OUT-1:0]  BIT0      = N_OUT'(1);

    seq_state_e        r_state;
    logic [FILT_W-1:0] r_filt_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [STAG_W-1:0] r_stag_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [N_OUT-1:0]  r_reset_out;
    logic              r_done;
    logic              r_busy;

    seq_state_e        w_state_nxt;
    logic [FILT_W-1:0] w_filt_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [STAG_W-1:0] w_stag_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [N_OUT-1:0]  w_reset_nxt;
    logic              w_done_nxt;

    logic              w_lock_s;
    logic              w_abort;
    logic [IDX_W-1:0]  w_idx_inc;
    logic [N_OUT-1:0]  w_clr_mask;

    // Raw lock only ever reaches the synchroniser.
    bit_sync u_lock_sync (
        .pclk  (pclk),
        .rst_n (rst_n),
        .i_d   (locked),
        .o_q   (w_lock_s)
    );

    assign w_abort    = seq_abort(w_lock_s, sw_reset_req);
    assign w_idx_inc  = r_idx + IDX_W'(1);
    // One-hot mask selecting the next bit to release.
    assign w_clr_mask = BIT0 << w_idx_inc;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_filt_nxt  = r_filt_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_stag_nxt  = r_stag_cnt;
        w_idx_nxt   = r_idx;
        w_reset_nxt = r_reset_out;
        w_done_nxt  = r_done;

        case (r_state)
            ST_ASSERT: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_filt_nxt  = '0;
                w_hold_nxt  = '0;
                w_stag_nxt  = '0;
                w_idx_nxt   = '0;
                w_reset_nxt = ALL_ON;
                w_done_nxt  = 1'b0;
            end

            // Software requests are deliberately ignored while waiting.
            ST_WAIT_LOCK: begin
                if (!w_lock_s) begin
                    w_filt_nxt = '0;
                end else if (r_filt_cnt == FILT_LAST) begin
                    w_filt_nxt  = r_filt_cnt + FILT_W'(1);
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_filt_nxt = r_filt_cnt + FILT_W'(1);
                end
            end

            // Bit 0 releases on the same edge that leaves HOLD.
            ST_HOLD: begin
                if (w_abort) begin
                    w_state_nxt = ST_ASSERT;
                    w_reset_nxt = ALL_ON;
                    w_done_nxt  = 1'b0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                    w_idx_nxt   = '0;
                    w_stag_nxt  = '0;
                    w_reset_nxt = r_reset_out & ~BIT0;
                    if (N_OUT == 1) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end

            // r_idx tracks the most recently released bit.
            ST_RELEASE: begin
                if (w_abort) begin
                    w_state_nxt = ST_ASSERT;
                    w_reset_nxt = ALL_ON;
                    w_done_nxt  = 1'b0;
                end else if (r_stag_cnt == STAG_LAST) begin
                    w_stag_nxt  = '0;
                    w_idx_nxt   = w_idx_inc;
                    w_reset_nxt = r_reset_out & ~w_clr_mask;
                    if (w_idx_inc == IDX_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_stag_nxt = r_stag_cnt + STAG_W'(1);
                end
            end

            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_ASSERT;
                    w_reset_nxt = ALL_ON;
                    w_done_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_ASSERT;
                w_reset_nxt = ALL_ON;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state     <= ST_ASSERT;
            r_filt_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_stag_cnt  <= '0;
            r_idx       <= '0;
            r_reset_out <= ALL_ON;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_filt_cnt  <= w_filt_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_stag_cnt  <= w_stag_nxt;
            r_idx       <= w_idx_nxt;
            r_reset_out <= w_reset_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != ST_RUN);
        end
    end

    assign reset_out = r_reset_out;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Directed, table-driven bench. Edge numbering: edge 1 is the first pclk
// edge sampled with rst_n = 1. Each table record gives the inputs applied
// for edge edge_no and the outputs expected right after that edge.
// A second instance (N_OUT=1, STAGGER_CYCLES=1) shares all inputs.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       pclk;
    logic       rst_n;
    logic       locked;
    logic       sw_reset_req;
    logic [3:0] reset_out;
    logic       done;
    logic       busy;
    logic [0:0] reset_out1;
    logic       done1;
    logic       busy1;

    typedef struct {
        int unsigned edge_no;
        logic        lk;
        logic        sw;
        logic [3:0]  e_rst;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t        tbl[$];
    int unsigned edge_n;
    int          checks;
    int          failures;
    string       scen;

    reset_sequencer dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .sw_reset_req (sw_reset_req),
        .reset_out    (reset_out),
        .done         (done),
        .busy         (busy)
    );

    reset_sequencer #(
        .N_OUT          (1),
        .STAGGER_CYCLES (1)
    ) dut1 (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .sw_reset_req (sw_reset_req),
        .reset_out    (reset_out1),
        .done         (done1),
        .busy         (busy1)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s edge=%0d got=%0h want=%0h", scen, name, edge_n, act, exp);
        end
    endtask

    task automatic add(input int unsigned e, input logic lk, input logic sw,
                       input logic [3:0] r, input logic d, input logic b);
        vec_t v;
        v.edge_no = e;
        v.lk      = lk;
        v.sw      = sw;
        v.e_rst   = r;
        v.e_done  = d;
        v.e_busy  = b;
        tbl.push_back(v);
    endtask

    task automatic run_tbl();
        vec_t v;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            while (edge_n + 1 < v.edge_no) tick();
            locked       = v.lk;
            sw_reset_req = v.sw;
            tick();
            sw_reset_req = 1'b0;
            chk("reset_out", 32'(reset_out), 32'(v.e_rst));
            chk("done",      32'(done),      32'(v.e_done));
            chk("busy",      32'(busy),      32'(v.e_busy));
        end
        tbl.delete();
    endtask

    task automatic do_reset(input logic lk);
        rst_n        = 1'b0;
        locked       = lk;
        sw_reset_req = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        edge_n = 0;
        chk("rst_reset_out", 32'(reset_out),  32'(4'hF));
        chk("rst_done",      32'(done),       32'(1'b0));
        chk("rst_busy",      32'(busy),       32'(1'b1));
        chk("rst_reset_out1", 32'(reset_out1), 32'(1'b1));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        edge_n       = 0;
        rst_n        = 1'b0;
        locked       = 1'b0;
        sw_reset_req = 1'b0;

        // Clean bring-up, lock high throughout.
        scen = "bringup";
        do_reset(1'b1);
        add(1,  1, 0, 4'hF, 0, 1);
        add(5,  1, 0, 4'hF, 0, 1);
        add(14, 1, 0, 4'hF, 0, 1);
        run_tbl();
        chk("n1_reset_out_14", 32'(reset_out1), 32'(1'b1));
        chk("n1_done_14",      32'(done1),      32'(1'b0));
        add(15, 1, 0, 4'hE, 0, 1);
        run_tbl();
        chk("n1_reset_out_15", 32'(reset_out1), 32'(1'b0));
        chk("n1_done_15",      32'(done1),      32'(1'b1));
        chk("n1_busy_15",      32'(busy1),      32'(1'b0));
        add(18, 1, 0, 4'hE, 0, 1);
        add(19, 1, 0, 4'hC, 0, 1);
        add(22, 1, 0, 4'hC, 0, 1);
        add(23, 1, 0, 4'h8, 0, 1);
        add(26, 1, 0, 4'h8, 0, 1);
        add(27, 1, 0, 4'h0, 1, 0);
        add(35, 1, 0, 4'h0, 1, 0);
        run_tbl();

        // One-cycle lock glitch during WAIT_LOCK restarts the filter.
        scen = "glitch";
        do_reset(1'b1);
        add(2,  1, 0, 4'hF, 0, 1);
        add(3,  0, 0, 4'hF, 0, 1);
        add(4,  1, 0, 4'hF, 0, 1);
        add(15, 1, 0, 4'hF, 0, 1);
        add(17, 1, 0, 4'hF, 0, 1);
        add(18, 1, 0, 4'hE, 0, 1);
        add(21, 1, 0, 4'hE, 0, 1);
        add(22, 1, 0, 4'hC, 0, 1);
        add(29, 1, 0, 4'h8, 0, 1);
        add(30, 1, 0, 4'h0, 1, 0);
        run_tbl();

        // Lock lost mid-release, later regained.
        scen = "lockloss";
        do_reset(1'b1);
        add(19, 1, 0, 4'hC, 0, 1);
        add(20, 0, 0, 4'hC, 0, 1);
        add(21, 0, 0, 4'hC, 0, 1);
        add(22, 0, 0, 4'hF, 0, 1);
        add(23, 0, 0, 4'hF, 0, 1);
        add(30, 0, 0, 4'hF, 0, 1);
        add(31, 1, 0, 4'hF, 0, 1);
        add(44, 1, 0, 4'hF, 0, 1);
        add(45, 1, 0, 4'hE, 0, 1);
        add(56, 1, 0, 4'h8, 0, 1);
        add(57, 1, 0, 4'h0, 1, 0);
        run_tbl();

        // Software reset in RUN; further requests in ASSERT/WAIT_LOCK ignored.
        scen = "swrun";
        do_reset(1'b1);
        add(27, 1, 0, 4'h0, 1, 0);
        add(30, 1, 1, 4'hF, 0, 1);
        add(31, 1, 1, 4'hF, 0, 1);
        add(32, 1, 1, 4'hF, 0, 1);
        add(43, 1, 0, 4'hF, 0, 1);
        add(44, 1, 0, 4'hE, 0, 1);
        add(47, 1, 0, 4'hE, 0, 1);
        add(48, 1, 0, 4'hC, 0, 1);
        add(52, 1, 0, 4'h8, 0, 1);
        add(55, 1, 0, 4'h8, 0, 1);
        add(56, 1, 0, 4'h0, 1, 0);
        run_tbl();

        // Software reset on the final release edge: abort wins.
        scen = "swfinal";
        do_reset(1'b1);
        add(26, 1, 0, 4'h8, 0, 1);
        add(27, 1, 1, 4'hF, 0, 1);
        run_tbl();
        for (int e = 28; e <= 38; e++) begin
            tick();
            chk("done_stays_low", 32'(done), 32'(1'b0));
        end
        add(40, 1, 0, 4'hF, 0, 1);
        add(41, 1, 0, 4'hE, 0, 1);
        run_tbl();

        // Software reset during HOLD.
        scen = "swhold";
        do_reset(1'b1);
        add(10, 1, 1, 4'hF, 0, 1);
        add(23, 1, 0, 4'hF, 0, 1);
        add(24, 1, 0, 4'hE, 0, 1);
        add(36, 1, 0, 4'h0, 1, 0);
        run_tbl();

        // rst_n pulsed mid-sequence overrides a simultaneous sw request.
        scen = "midrst";
        do_reset(1'b1);
        add(16, 1, 0, 4'hE, 0, 1);
        run_tbl();
        rst_n        = 1'b0;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        chk("midrst_reset_out", 32'(reset_out), 32'(4'hF));
        chk("midrst_done",      32'(done),      32'(1'b0));
        chk("midrst_busy",      32'(busy),      32'(1'b1));
        rst_n  = 1'b1;
        edge_n = 0;
        add(1,  1, 0, 4'hF, 0, 1);
        add(14, 1, 0, 4'hF, 0, 1);
        add(15, 1, 0, 4'hE, 0, 1);
        add(27, 1, 0, 4'h0, 1, 0);
        run_tbl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
